// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI/OPI command-phase sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPCODE = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    DATA   = 3'd4,
    ERR    = 3'd5
  } phase_t;

  localparam logic [2:0] WRAP_LIN = 3'd0;
  localparam logic [2:0] WRAP_8   = 3'd1;
  localparam logic [2:0] WRAP_16  = 3'd2;
  localparam logic [2:0] WRAP_32  = 3'd3;
  localparam logic [2:0] WRAP_64  = 3'd4;

  localparam logic LANE_X1 = 1'b0;
  localparam logic LANE_X8 = 1'b1;

  // x8 opcodes carry a second, inverted copy for integrity checking
  function automatic logic [5:0] opc_len(input logic lane);
    return (lane == LANE_X8) ? 6'd2 : 6'd8;
  endfunction

  function automatic logic [5:0] addr_len(input logic lane, input int addr_w);
    return (lane == LANE_X8) ? 6'(addr_w / 8) : 6'(addr_w);
  endfunction

endpackage

// File: rtl/spi_wrap_addr.sv
// Next data address: linear increment or wrap within an aligned 8/16/32/64-byte burst.
module spi_wrap_addr
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [2:0]        wrap_sel,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] mask;

  // Bits under the mask take the incremented value; bits above it are held
  always_comb begin
    inc  = cur_addr + ADDR_W'(1);
    mask = '1;
    case (wrap_sel)
      WRAP_8:  mask = ADDR_W'(7);
      WRAP_16: mask = ADDR_W'(15);
      WRAP_32: mask = ADDR_W'(31);
      WRAP_64: mask = ADDR_W'(63);
      default: mask = '1;
    endcase
    next_addr = (cur_addr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/spi_phase_seq.sv
// Registered command-phase sequencer: walks a flash transaction through
// opcode, address, dummy and data phases in x1 or x8 lane mode.
module spi_phase_seq
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_DUMMY = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cs_active,
  input  logic                           sck_tick,
  input  logic [7:0]                     sio_in,
  input  logic                           opi_mode,
  input  logic                           desc_has_addr,
  input  logic [$clog2(MAX_DUMMY+1)-1:0] desc_dummy,
  input  logic                           desc_has_data,
  input  logic [2:0]                     wrap_sel,
  output logic [2:0]                     phase,
  output logic                           opc_valid,
  output logic [7:0]                     opcode,
  output logic                           addr_valid,
  output logic [ADDR_W-1:0]              addr,
  output logic                           dummy_done,
  output logic                           byte_stb,
  output logic [7:0]                     rx_byte,
  output logic [ADDR_W-1:0]              cur_addr,
  output logic                           err
);

  localparam int DW = $clog2(MAX_DUMMY + 1);

  phase_t            state;
  logic              lane_r;
  logic [5:0]        cnt;
  logic [7:0]        byte_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic [DW-1:0]     dummy_r;
  logic              has_data_r;
  logic [2:0]        wrap_r;

  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] addr_in;
  logic [DW-1:0]     dummy_sat;
  phase_t            post_opc;
  phase_t            post_addr;
  logic [ADDR_W-1:0] next_addr;

  assign phase = state;

  // Shift-in values for this tick plus the phase that follows opcode/address
  always_comb begin
    byte_in   = (lane_r == LANE_X8) ? sio_in : {byte_sh[6:0], sio_in[0]};
    addr_in   = (lane_r == LANE_X8) ? {addr_sh[ADDR_W-9:0], sio_in}
                                    : {addr_sh[ADDR_W-2:0], sio_in[0]};
    dummy_sat = (desc_dummy > DW'(MAX_DUMMY)) ? DW'(MAX_DUMMY) : desc_dummy;
    post_opc  = desc_has_addr        ? ADDR  :
                (dummy_sat != '0)    ? DUMMY :
                desc_has_data        ? DATA  : ERR;
    post_addr = (dummy_r != '0)      ? DUMMY :
                has_data_r           ? DATA  : ERR;
  end

  spi_wrap_addr #(.ADDR_W(ADDR_W)) u_wrap (
    .cur_addr  (cur_addr),
    .wrap_sel  (wrap_r),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane_r     <= LANE_X1;
      cnt        <= '0;
      byte_sh    <= '0;
      addr_sh    <= '0;
      dummy_r    <= '0;
      has_data_r <= 1'b0;
      wrap_r     <= WRAP_LIN;
      opc_valid  <= 1'b0;
      opcode     <= '0;
      addr_valid <= 1'b0;
      addr       <= '0;
      dummy_done <= 1'b0;
      byte_stb   <= 1'b0;
      rx_byte    <= '0;
      cur_addr   <= '0;
      err        <= 1'b0;
    end else begin
      opc_valid  <= 1'b0;
      addr_valid <= 1'b0;
      dummy_done <= 1'b0;
      byte_stb   <= 1'b0;
      err        <= 1'b0;
      if (byte_stb) cur_addr <= next_addr;

      // Chip-select release aborts whatever phase is in progress
      if (!cs_active) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state  <= OPCODE;
            lane_r <= opi_mode;
            cnt    <= '0;
          end
          OPCODE: if (sck_tick) begin
            byte_sh <= byte_in;
            cnt     <= cnt + 6'd1;
            if (cnt == opc_len(lane_r) - 6'd1) begin
              cnt <= '0;
              if (lane_r == LANE_X8 && sio_in != ~byte_sh) begin
                state <= ERR;
                err   <= 1'b1;
              end else begin
                opcode     <= (lane_r == LANE_X8) ? byte_sh : byte_in;
                opc_valid  <= 1'b1;
                dummy_r    <= dummy_sat;
                has_data_r <= desc_has_data;
                state      <= post_opc;
              end
            end
          end
          ADDR: if (sck_tick) begin
            addr_sh <= addr_in;
            cnt     <= cnt + 6'd1;
            if (cnt == addr_len(lane_r, ADDR_W) - 6'd1) begin
              cnt        <= '0;
              addr       <= addr_in;
              cur_addr   <= addr_in;
              wrap_r     <= wrap_sel;
              addr_valid <= 1'b1;
              state      <= post_addr;
            end
          end
          DUMMY: if (sck_tick) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(dummy_r) - 6'd1) begin
              cnt        <= '0;
              dummy_done <= 1'b1;
              state      <= has_data_r ? DATA : ERR;
            end
          end
          DATA: if (sck_tick) begin
            byte_sh <= byte_in;
            if (lane_r == LANE_X8 || cnt == 6'd7) begin
              rx_byte  <= byte_in;
              byte_stb <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          ERR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_phase_seq.sv
// Directed self-checking bench for spi_phase_seq with hand-computed expectations.
module tb_spi_phase_seq;

  localparam int ADDR_W    = 32;
  localparam int MAX_DUMMY = 20;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_OPC   = 3'd1;
  localparam logic [2:0] P_ADDR  = 3'd2;
  localparam logic [2:0] P_DUMMY = 3'd3;
  localparam logic [2:0] P_DATA  = 3'd4;
  localparam logic [2:0] P_ERR   = 3'd5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs_active;
  logic              sck_tick;
  logic [7:0]        sio_in;
  logic              opi_mode;
  logic              desc_has_addr;
  logic [4:0]        desc_dummy;
  logic              desc_has_data;
  logic [2:0]        wrap_sel;
  logic [2:0]        phase;
  logic              opc_valid;
  logic [7:0]        opcode;
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic              dummy_done;
  logic              byte_stb;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wrap_bytes [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [31:0] wrap_exp   [4] = '{32'hFE, 32'hFF, 32'hF8, 32'hF9};

  always #5 clk = ~clk;

  spi_phase_seq #(.ADDR_W(ADDR_W), .MAX_DUMMY(MAX_DUMMY)) dut (
    .clk           (clk),
    .rst           (rst),
    .cs_active     (cs_active),
    .sck_tick      (sck_tick),
    .sio_in        (sio_in),
    .opi_mode      (opi_mode),
    .desc_has_addr (desc_has_addr),
    .desc_dummy    (desc_dummy),
    .desc_has_data (desc_has_data),
    .wrap_sel      (wrap_sel),
    .phase         (phase),
    .opc_valid     (opc_valid),
    .opcode        (opcode),
    .addr_valid    (addr_valid),
    .addr          (addr),
    .dummy_done    (dummy_done),
    .byte_stb      (byte_stb),
    .rx_byte       (rx_byte),
    .cur_addr      (cur_addr),
    .err           (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One SCK sampling tick; returns at the negedge after the consuming posedge
  task automatic applyStimulus(input logic [7:0] v);
    sck_tick = 1'b1;
    sio_in   = v;
    @(negedge clk);
    sck_tick = 1'b0;
  endtask

  task automatic sendX1(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus({7'd0, v[i]});
  endtask

  task automatic startTxn(input logic m);
    opi_mode  = m;
    cs_active = 1'b1;
    @(negedge clk);
    opi_mode  = ~m;
  endtask

  task automatic endTxn();
    cs_active = 1'b0;
    sck_tick  = 1'b1;
    sio_in    = 8'hFF;
    @(negedge clk);
    sck_tick  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cs_active = 1'b0; sck_tick = 1'b0; sio_in = '0; opi_mode = 1'b0;
    desc_has_addr = 1'b0; desc_dummy = '0; desc_has_data = 1'b0; wrap_sel = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_phase",    32'(phase),    32'(P_IDLE));
    checkOutput("rst_opcode",   32'(opcode),   32'h0);
    checkOutput("rst_cur_addr", cur_addr,      32'h0);
    checkOutput("rst_pulses",   32'({opc_valid, addr_valid, dummy_done, byte_stb, err}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // x1 full transaction: opcode 0x0B, address, 8 dummy, one data byte
    desc_has_addr = 1'b1; desc_dummy = 5'd8; desc_has_data = 1'b1; wrap_sel = 3'd0;
    startTxn(1'b0);
    checkOutput("t1_phase_opc", 32'(phase), 32'(P_OPC));
    sendX1(32'h0B >> 1, 7);
    checkOutput("t1_opc_early", 32'(opc_valid), 32'h0);
    applyStimulus(8'h01);
    checkOutput("t1_opc_valid", 32'(opc_valid), 32'h1);
    checkOutput("t1_opcode",    32'(opcode),    32'h0B);
    checkOutput("t1_phase_adr", 32'(phase),     32'(P_ADDR));
    sendX1(32'h1234 >> 1, 31);
    checkOutput("t1_adr_early", 32'(addr_valid), 32'h0);
    applyStimulus(8'h00);
    checkOutput("t1_adr_valid", 32'(addr_valid), 32'h1);
    checkOutput("t1_addr",      addr,            32'h1234);
    checkOutput("t1_cur_addr",  cur_addr,        32'h1234);
    checkOutput("t1_phase_dum", 32'(phase),      32'(P_DUMMY));
    repeat (7) applyStimulus(8'h00);
    checkOutput("t1_dum_early", 32'(dummy_done), 32'h0);
    applyStimulus(8'h00);
    checkOutput("t1_dum_done",  32'(dummy_done), 32'h1);
    checkOutput("t1_phase_dat", 32'(phase),      32'(P_DATA));
    sendX1(32'hA5 >> 1, 7);
    checkOutput("t1_stb_early", 32'(byte_stb), 32'h0);
    applyStimulus(8'h01);
    checkOutput("t1_byte_stb",  32'(byte_stb), 32'h1);
    checkOutput("t1_rx_byte",   32'(rx_byte),  32'hA5);
    @(negedge clk);
    checkOutput("t1_cur_next",  cur_addr,        32'h1235);
    checkOutput("t1_stb_once",  32'(byte_stb),   32'h0);
    endTxn();
    checkOutput("t1_idle",      32'(phase),      32'(P_IDLE));
    checkOutput("t1_opc_hold",  32'(opcode),     32'h0B);

    // x8 with 8-byte wrap starting at 0xFE
    desc_dummy = 5'd0; wrap_sel = 3'd1;
    startTxn(1'b1);
    applyStimulus(8'hEE);
    applyStimulus(8'h11);
    checkOutput("t2_opc_valid", 32'(opc_valid), 32'h1);
    checkOutput("t2_opcode",    32'(opcode),    32'hEE);
    checkOutput("t2_phase_adr", 32'(phase),     32'(P_ADDR));
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'hFE);
    checkOutput("t2_adr_valid", 32'(addr_valid), 32'h1);
    checkOutput("t2_phase_dat", 32'(phase),      32'(P_DATA));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(wrap_bytes[k]);
      checkOutput("t2_byte_stb", 32'(byte_stb), 32'h1);
      checkOutput("t2_rx_byte",  32'(rx_byte),  32'(wrap_bytes[k]));
      checkOutput("t2_cur_addr", cur_addr,      wrap_exp[k]);
    end
    endTxn();
    checkOutput("t2_idle", 32'(phase), 32'(P_IDLE));

    // x8 opcode integrity failure
    startTxn(1'b1);
    applyStimulus(8'hEE);
    applyStimulus(8'h12);
    checkOutput("t3_err",       32'(err),       32'h1);
    checkOutput("t3_no_opc",    32'(opc_valid), 32'h0);
    checkOutput("t3_phase_err", 32'(phase),     32'(P_ERR));
    applyStimulus(8'h00);
    checkOutput("t3_err_once",  32'(err),       32'h0);
    checkOutput("t3_err_stay",  32'(phase),     32'(P_ERR));
    checkOutput("t3_opc_hold",  32'(opcode),    32'hEE);
    endTxn();
    checkOutput("t3_idle",      32'(phase),     32'(P_IDLE));

    // Linear rollover at the top of the address space (wrap_sel 5 is linear)
    wrap_sel = 3'd5;
    startTxn(1'b1);
    applyStimulus(8'h03);
    applyStimulus(8'hFC);
    repeat (4) applyStimulus(8'hFF);
    checkOutput("t4_addr",      addr,           32'hFFFF_FFFF);
    applyStimulus(8'h5A);
    checkOutput("t4_byte_stb",  32'(byte_stb),  32'h1);
    checkOutput("t4_rx_byte",   32'(rx_byte),   32'h5A);
    @(negedge clk);
    checkOutput("t4_rollover",  cur_addr,       32'h0);
    endTxn();

    // Abort during address, then a back-to-back clean x1 transaction
    startTxn(1'b0);
    sendX1(32'h03, 8);
    checkOutput("t5_opc_valid", 32'(opc_valid),  32'h1);
    sendX1(32'h5, 3);
    checkOutput("t5_mid_addr",  32'(phase),      32'(P_ADDR));
    endTxn();
    checkOutput("t5_abort_idle", 32'(phase),     32'(P_IDLE));
    checkOutput("t5_no_adr_vld", 32'(addr_valid), 32'h0);
    checkOutput("t5_addr_hold",  addr,           32'hFFFF_FFFF);
    desc_has_addr = 1'b0; desc_dummy = 5'd0; desc_has_data = 1'b1;
    startTxn(1'b0);
    checkOutput("t5_b2b_opc",   32'(phase),     32'(P_OPC));
    sendX1(32'h03, 8);
    checkOutput("t5_opc2_vld",  32'(opc_valid), 32'h1);
    checkOutput("t5_opcode2",   32'(opcode),    32'h03);
    checkOutput("t5_phase_dat", 32'(phase),     32'(P_DATA));
    sendX1(32'h3C, 8);
    checkOutput("t5_byte_stb",  32'(byte_stb),  32'h1);
    checkOutput("t5_rx_byte",   32'(rx_byte),   32'h3C);
    @(negedge clk);
    checkOutput("t5_cur_addr",  cur_addr,       32'h1);
    endTxn();

    // Dummy count saturation, then reset in the middle of DATA
    desc_dummy = 5'd31;
    startTxn(1'b1);
    applyStimulus(8'h0B);
    applyStimulus(8'hF4);
    checkOutput("t6_phase_dum", 32'(phase), 32'(P_DUMMY));
    repeat (19) applyStimulus(8'h00);
    checkOutput("t6_dum_early", 32'(dummy_done), 32'h0);
    applyStimulus(8'h00);
    checkOutput("t6_dum_done",  32'(dummy_done), 32'h1);
    checkOutput("t6_phase_dat", 32'(phase),      32'(P_DATA));
    applyStimulus(8'h77);
    checkOutput("t6_rx_byte",   32'(rx_byte),    32'h77);
    rst = 1'b1; sck_tick = 1'b1; sio_in = 8'h88;
    @(negedge clk);
    sck_tick = 1'b0;
    checkOutput("t6_rst_phase",  32'(phase),    32'(P_IDLE));
    checkOutput("t6_rst_opcode", 32'(opcode),   32'h0);
    checkOutput("t6_rst_addr",   addr,          32'h0);
    checkOutput("t6_rst_cur",    cur_addr,      32'h0);
    checkOutput("t6_rst_rx",     32'(rx_byte),  32'h0);
    checkOutput("t6_rst_stb",    32'(byte_stb), 32'h0);
    rst = 1'b0;
    cs_active = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
